// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, converter state encoding and width helper
package bcd_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

    // Smallest w with 2^w > 10^digits - 1, i.e. 2^w >= 10^digits.
    function automatic int unsigned min_bin_width(input int unsigned digits);
        longint unsigned limit;
        int unsigned     w;
        limit = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            limit = limit * 64'd10;
        end
        w = 0;
        for (int unsigned i = 1; i < 64; i++) begin
            if (w == 0 && (64'd1 << i) >= limit) begin
                w = i;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2binary_reverse_dabble_if.sv
// rtl/bcd2binary_reverse_dabble_if.sv - input/output handshake bundle of the BCD-to-binary converter
interface bcd2binary_reverse_dabble_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    import bcd_pkg::*;

    logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd;
    logic                          in_valid;
    logic                          in_ready;
    logic [BIN_W-1:0]              out_binary;
    logic                          out_bcd_error;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output in_bcd, in_valid, out_ready,
        input  in_ready, out_binary, out_bcd_error, out_valid
    );

    modport slave (
        input  in_bcd, in_valid, out_ready,
        output in_ready, out_binary, out_bcd_error, out_valid
    );

endinterface

// File: rtl/bcd_digit_sub3.sv
// rtl/bcd_digit_sub3.sv - one reverse-dabble digit correction: subtract 3 when the digit is 8 or more
module bcd_digit_sub3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = digit_in[BCD_DIGIT_W-1] ? (digit_in - 4'd3) : digit_in;

endmodule

// File: rtl/bcd2binary_reverse_dabble.sv
// rtl/bcd2binary_reverse_dabble.sv - sequential packed-BCD to binary converter (reverse double dabble)
module bcd2binary_reverse_dabble
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    bcd2binary_reverse_dabble_if.slave  bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_t               state;
    logic [CNT_W-1:0]         counter;
    logic [BCD_W+BIN_W-1:0]   scratch;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+BIN_W-1:0]   next_scratch;
    logic [BIN_W-1:0]         out_binary_q;
    logic                     out_bcd_error_q;
    logic                     out_valid_q;
    logic                     bad_digit;

    assign shifted      = scratch >> 1;
    assign next_scratch = {bcd_adj, shifted[BIN_W-1:0]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_sub3 u_sub3 (
            .digit_in  (shifted[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'(BCD_MAX_DIGIT)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // in_ready is masked by rst so nothing is accepted on a reset edge.
    assign bus.in_ready      = (state == IDLE) && !rst;
    assign bus.out_binary    = out_binary_q;
    assign bus.out_bcd_error = out_bcd_error_q;
    assign bus.out_valid     = out_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            counter         <= '0;
            scratch         <= '0;
            out_binary_q    <= '0;
            out_bcd_error_q <= 1'b0;
            out_valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bad_digit) begin
                            out_binary_q    <= '0;
                            out_bcd_error_q <= 1'b1;
                            out_valid_q     <= 1'b1;
                            state           <= DONE;
                        end else begin
                            scratch <= {bus.in_bcd, {BIN_W{1'b0}}};
                            counter <= '0;
                            state   <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    scratch <= next_scratch;
                    counter <= counter + 1'b1;
                    if (counter == CNT_W'(BIN_W - 1)) begin
                        out_binary_q    <= next_scratch[BIN_W-1:0];
                        out_bcd_error_q <= 1'b0;
                        out_valid_q     <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A legal input leaves nothing behind in the BCD half once all bits are shifted out.
    a_bcd_part_drained: assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !out_bcd_error_q) |-> (scratch[BCD_W+BIN_W-1:BIN_W] == '0));

endmodule

// File: tb/tb_bcd2binary_reverse_dabble.sv
// tb/tb_bcd2binary_reverse_dabble.sv - scoreboard bench for the BCD-to-binary converter
module tb_bcd2binary_reverse_dabble;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    typedef struct packed {
        logic [BIN_W-1:0] binary;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bp_en = 1'b0;
    logic bp_ready = 1'b1;
    logic dir_ready = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    exp_t exp_q[$];

    bcd2binary_reverse_dabble_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd2binary_reverse_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.out_ready = bp_en ? bp_ready : dir_ready;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake is visible at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.out_binary), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                pops++;
                check("out_binary", 32'(bus.out_binary), 32'(e.binary));
                check("out_bcd_error", 32'(bus.out_bcd_error), 32'(e.err));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bp_ready = ($urandom_range(0, 3) != 0);
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [11:0] bcd, input logic [BIN_W-1:0] eb, input logic ee);
        bit accepted;
        exp_t e;
        accepted = 1'b0;
        bus.in_bcd   = bcd;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 1000 && !accepted; n++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                e.binary = eb;
                e.err    = ee;
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // Edges from acceptance until out_valid is seen; in_ready must stay low meanwhile.
    task automatic wait_result(input string name, input int exp_edges);
        int n;
        int rdy_hi;
        n = 0;
        rdy_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.in_ready === 1'b1) rdy_hi++;
        end while (bus.out_valid !== 1'b1 && n < 100);
        check({name, "_latency"}, 32'(n - 1), 32'(exp_edges));
        check({name, "_in_ready_low"}, 32'(rdy_hi), 32'd0);
    endtask

    initial begin
        int sweep_base;
        bus.in_bcd   = '0;
        bus.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_binary", 32'(bus.out_binary), 32'd0);
        check("reset_out_bcd_error", 32'(bus.out_bcd_error), 32'd0);
        @(posedge clk);
        #1;

        send(12'h255, 10'd255, 1'b0);
        wait_result("conv_255", 10);
        @(negedge clk);
        check("single_cycle_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        send(12'h999, 10'b1111100111, 1'b0);
        wait_result("conv_999", 10);
        @(posedge clk);
        #1;
        send(12'h000, 10'd0, 1'b0);
        wait_result("conv_000", 10);
        @(posedge clk);
        #1;

        send(12'h0A5, 10'd0, 1'b1);
        wait_result("bad_digit", 0);
        @(posedge clk);
        #1;
        send(12'h100, 10'd100, 1'b0);
        wait_result("conv_100", 10);
        @(posedge clk);
        #1;

        dir_ready = 1'b0;
        send(12'h407, 10'd407, 1'b0);
        wait_result("conv_407", 10);
        @(posedge clk);
        #1;
        bus.in_bcd   = 12'h123;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_binary", 32'(bus.out_binary), 32'd407);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        dir_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        send(12'h876, 10'd876, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_reset_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_reset_out_binary", 32'(bus.out_binary), 32'd0);
        check("mid_reset_in_ready_after", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(12'h031, 10'd31, 1'b0);
        wait_result("conv_031", 10);
        @(posedge clk);
        #1;

        sweep_base = pops + exp_q.size();
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [11:0] bcd;
            bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(bcd, 10'(i), 1'b0);
        end
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("sweep_count", 32'(pops - sweep_base), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
